// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcodes, ALU operation codes and the ID/EX control bundle.
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_MULT  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBI  = 6'h0a;
  localparam logic [5:0] OP_SUBUI = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LHI   = 6'h0f;
  localparam logic [5:0] OP_JRF   = 6'h12;
  localparam logic [5:0] OP_SLLI  = 6'h14;
  localparam logic [5:0] OP_SRLI  = 6'h16;
  localparam logic [5:0] OP_SRAI  = 6'h17;
  localparam logic [5:0] OP_SEQI  = 6'h18;
  localparam logic [5:0] OP_SNEI  = 6'h19;
  localparam logic [5:0] OP_SLTI  = 6'h1a;
  localparam logic [5:0] OP_SGTI  = 6'h1b;
  localparam logic [5:0] OP_SLEI  = 6'h1c;
  localparam logic [5:0] OP_SGEI  = 6'h1d;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] ALU_SLL  = 6'h04;
  localparam logic [5:0] ALU_SRL  = 6'h06;
  localparam logic [5:0] ALU_SRA  = 6'h07;
  localparam logic [5:0] ALU_NOPJ = 6'h11;
  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_ADDU = 6'h21;
  localparam logic [5:0] ALU_SUB  = 6'h22;
  localparam logic [5:0] ALU_SUBU = 6'h23;
  localparam logic [5:0] ALU_AND  = 6'h24;
  localparam logic [5:0] ALU_OR   = 6'h25;
  localparam logic [5:0] ALU_XOR  = 6'h26;
  localparam logic [5:0] ALU_SEQ  = 6'h28;
  localparam logic [5:0] ALU_SNE  = 6'h29;
  localparam logic [5:0] ALU_SLT  = 6'h2a;
  localparam logic [5:0] ALU_SGT  = 6'h2b;
  localparam logic [5:0] ALU_SLE  = 6'h2c;
  localparam logic [5:0] ALU_SGE  = 6'h2d;

  typedef struct packed {
    logic       regdst;
    logic       branch;
    logic       jump;
    logic       jr;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [5:0] aluop;
  } ctrl_bundle_t;

  // Immediate ALU forms share one control pattern; only the ALU op differs.
  function automatic ctrl_bundle_t imm_ctrl(input logic [5:0] aluop);
    ctrl_bundle_t c;
    c          = '0;
    c.alusrc   = 1'b1;
    c.memtoreg = 1'b1;
    c.regwrite = 1'b1;
    c.aluop    = aluop;
    return c;
  endfunction

endpackage

// File: rtl/dlx_decode.sv
// Combinational DLX opcode/funct decode into the control bundle, with an
// illegal-opcode flag and a flag saying whether the instruction reads rt.
module dlx_decode
  import dlx_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output ctrl_bundle_t ctrl,
  output logic         reads_rt,
  output logic         illegal
);

  // Decode table; anything not listed is an all-zero bundle flagged illegal.
  always_comb begin
    ctrl     = '0;
    reads_rt = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE, OP_MULT: begin
        ctrl.regdst   = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = funct;
        reads_rt      = 1'b1;
      end
      OP_ADDI:  ctrl = imm_ctrl(ALU_ADD);
      OP_ADDUI: ctrl = imm_ctrl(ALU_ADDU);
      OP_SUBI:  ctrl = imm_ctrl(ALU_SUB);
      OP_SUBUI: ctrl = imm_ctrl(ALU_SUBU);
      OP_ANDI:  ctrl = imm_ctrl(ALU_AND);
      OP_ORI:   ctrl = imm_ctrl(ALU_OR);
      OP_XORI:  ctrl = imm_ctrl(ALU_XOR);
      OP_SLLI:  ctrl = imm_ctrl(ALU_SLL);
      OP_SRLI:  ctrl = imm_ctrl(ALU_SRL);
      OP_SRAI:  ctrl = imm_ctrl(ALU_SRA);
      OP_SEQI:  ctrl = imm_ctrl(ALU_SEQ);
      OP_SNEI:  ctrl = imm_ctrl(ALU_SNE);
      OP_SLTI:  ctrl = imm_ctrl(ALU_SLT);
      OP_SGTI:  ctrl = imm_ctrl(ALU_SGT);
      OP_SLEI:  ctrl = imm_ctrl(ALU_SLE);
      OP_SGEI:  ctrl = imm_ctrl(ALU_SGE);
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LHI: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALU_ADD;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
        reads_rt      = 1'b1;
      end
      OP_BEQ, OP_BNEZ: begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALU_SUB;
        reads_rt    = (opcode == OP_BEQ);
      end
      OP_J: begin
        ctrl.jump  = 1'b1;
        ctrl.aluop = ALU_NOPJ;
      end
      OP_JRF: begin
        ctrl.jr    = 1'b1;
        ctrl.aluop = ALU_NOPJ;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dlx_ctrl_pipe.sv
// Registered DLX control stage: decode, load-use stall, multi-cycle Mult FSM and
// redirect flushes. Define DLX_CTRL_ILLEGAL_TRAP_EN for a sticky illegal-opcode trap.
module dlx_ctrl_pipe
  import dlx_pkg::*;
#(
  parameter int ALUOP_W     = 6,
  parameter int REG_W       = 5,
  parameter int MULT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               branch_taken,
  input  logic               jump_taken,
  input  logic               jr_taken,
  output logic               stall,
  output logic               if_flush,
  output logic               id_flush,
  output logic               ex_flush,
  output logic               ex_valid,
  output logic               ex_regdst,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               ex_jr,
  output logic               ex_memread,
  output logic               ex_memtoreg,
  output logic               ex_memwrite,
  output logic               ex_alusrc,
  output logic               ex_regwrite,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [REG_W-1:0]   ex_dst,
  output logic               illegal
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} mult_state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES - 1);

  mult_state_t  state_r, state_s;
  logic [3:0]   cnt_r, cnt_s;
  ctrl_bundle_t dec_s, nxt_s;
  logic         dec_rt_s, dec_ill_s;
  logic         redirect_s, busy_s, load_use_s, trap_s, issue_s, mult_go_s;
  logic [ALUOP_W-1:0] nxt_aluop_s;
  logic [REG_W-1:0]   nxt_dst_s;

  dlx_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .ctrl     (dec_s),
    .reads_rt (dec_rt_s),
    .illegal  (dec_ill_s)
  );

  assign redirect_s = branch_taken | jump_taken | jr_taken;
  assign busy_s     = (state_r == S_BUSY);
  assign load_use_s = id_valid & ex_valid & ex_memread & ex_regwrite &
                      (ex_dst != {REG_W{1'b0}}) &
                      ((ex_dst == id_rs) | (dec_rt_s & (ex_dst == id_rt)));
  assign issue_s    = id_valid & ~redirect_s & ~busy_s & ~load_use_s & ~trap_s;
  assign mult_go_s  = issue_s & ~dec_ill_s & (opcode == OP_MULT);

  assign stall    = busy_s | load_use_s | trap_s;
  assign if_flush = redirect_s;
  assign id_flush = redirect_s;
  assign ex_flush = redirect_s;

`ifdef DLX_CTRL_ILLEGAL_TRAP_EN
  logic ill_r;

  // Sticky trap: set when an illegal instruction would have issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_r <= 1'b0;
    end else if (issue_s & dec_ill_s) begin
      ill_r <= 1'b1;
    end
  end

  assign trap_s  = ill_r;
  assign illegal = ill_r;
`else
  assign trap_s  = 1'b0;
  assign illegal = id_valid & dec_ill_s;
`endif

  // Mult occupancy FSM; a redirect does not abort an in-flight multiply.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (mult_go_s && (MULT_CYCLES > 1)) begin
          state_s = S_BUSY;
          cnt_s   = MULT_CNT;
        end else begin
          state_s = S_IDLE;
          cnt_s   = 4'd0;
        end
      end
      S_BUSY: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_BUSY;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next bundle: the decode when issuing a legal instruction, otherwise a bubble.
  always_comb begin
    nxt_s     = '0;
    nxt_dst_s = {REG_W{1'b0}};
    if (issue_s && !dec_ill_s) begin
      nxt_s     = dec_s;
      nxt_dst_s = dec_s.regdst ? id_rd : id_rt;
    end else begin
      nxt_s     = '0;
      nxt_dst_s = {REG_W{1'b0}};
    end
  end

  if (ALUOP_W == 6) begin : g_aluop_same
    assign nxt_aluop_s = nxt_s.aluop;
  end else if (ALUOP_W > 6) begin : g_aluop_ext
    assign nxt_aluop_s = {{(ALUOP_W - 6){1'b0}}, nxt_s.aluop};
  end else begin : g_aluop_trunc
    assign nxt_aluop_s = nxt_s.aluop[ALUOP_W-1:0];
  end

  // ID/EX bundle register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_branch   <= 1'b0;
      ex_jump     <= 1'b0;
      ex_jr       <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_aluop    <= {ALUOP_W{1'b0}};
      ex_dst      <= {REG_W{1'b0}};
    end else begin
      ex_valid    <= issue_s & ~dec_ill_s;
      ex_regdst   <= nxt_s.regdst;
      ex_branch   <= nxt_s.branch;
      ex_jump     <= nxt_s.jump;
      ex_jr       <= nxt_s.jr;
      ex_memread  <= nxt_s.memread;
      ex_memtoreg <= nxt_s.memtoreg;
      ex_memwrite <= nxt_s.memwrite;
      ex_alusrc   <= nxt_s.alusrc;
      ex_regwrite <= nxt_s.regwrite;
      ex_aluop    <= nxt_aluop_s;
      ex_dst      <= nxt_dst_s;
    end
  end

endmodule

// File: doc/dlx_ctrl_pipe.md
# dlx_ctrl_pipe

Registered, parametrised successor to the DLX combinational control decoder. Decodes the ID-stage opcode/funct into the ID/EX control bundle and registers it. Adds load-use hazard stall, a multi-cycle multiply busy FSM, and redirect flush generation. Sits between the IF/ID register and the EX stage and drives the pipeline stall and flush lines.

## Interface
- `ALUOP_W`, default 6: ALU op width; funct is zero-extended or truncated to this width.
- `REG_W`, default 5: register-address width.
- `MULT_CYCLES`, default 4: EX occupancy of Mult (opcode 0x01); legal range 1..15.
- `clk` in, 1: clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `id_valid` in, 1: IF/ID holds a real instruction.
- `opcode`, `funct` in, 6 each: instruction fields.
- `id_rs`, `id_rt`, `id_rd` in, REG_W each: register fields.
- `branch_taken`, `jump_taken`, `jr_taken` in, 1 each: redirect resolved this cycle.
- `stall` out, 1: hold PC and IF/ID.
- `if_flush`, `id_flush`, `ex_flush` out, 1 each: squash those stages.
- `ex_valid` out, 1: bundle is a real instruction.
- `ex_regdst`, `ex_branch`, `ex_jump`, `ex_jr`, `ex_memread`, `ex_memtoreg`, `ex_memwrite`, `ex_alusrc`, `ex_regwrite` out, 1 each: registered control bundle.
- `ex_aluop` out, ALUOP_W: registered ALU op.
- `ex_dst` out, REG_W: destination register (rd if regdst, else rt).
- `illegal` out, 1: illegal-opcode indication.

## Operation
- Decode table:
  - Immediate ALU ops ADDI..SGEI use ALUOp 0x20–0x2d / 0x04 / 0x06 / 0x07, with regdst=0, alusrc=1, memtoreg=1, regwrite=1.
  - R and Mult: regdst=1, aluop=funct.
  - LW/LB/LH/LBU/LHU/LHI: memread=1, aluop=0x20.
  - SW/SB/SH: memwrite=1, regwrite=0.
  - BEQ/BNEZ: branch=1, aluop=0x22.
  - J: jump=1. JR (0x12): jr=1. Both use aluop=0x11.
- Unlisted opcodes, including JAL/JALR, decode to an all-zero bundle with `illegal`=1. No X is ever driven.
- Redirect (`branch_taken|jump_taken|jr_taken`):
  - `if_flush`, `id_flush` and `ex_flush` all go high combinationally in the same cycle.
  - The next bundle is a bubble (all zero, `ex_valid`=0).
- Load-use hazard, combinational:
  - Condition: `ex_valid & ex_memread & ex_regwrite & ex_dst!=0`, and `ex_dst` matches `id_rs`, or matches `id_rt` when the ID op reads rt (R, Mult, stores, BEQ).
  - Response: `stall`=1 for one cycle and the next bundle is a bubble.
- Mult FSM, states IDLE and BUSY, 4-bit counter:
  - IDLE→BUSY: a valid Mult is issued and MULT_CYCLES>1. The counter loads MULT_CYCLES-1.
  - BUSY: `stall`=1, bundles are bubbles, and the counter decrements each cycle.
  - BUSY→IDLE: when the counter is 1 (so 0 after the decrement).
- Priority, highest first:
  1. Reset.
  2. Redirect. Forces a bubble. It does not abort BUSY, because the multiply is older than the redirect. While BUSY, `stall` stays high alongside the flush lines.
  3. BUSY stall.
  4. Load-use stall.
  5. Normal issue.
- `id_valid`=0 produces a bubble and never triggers hazards or FSM entry.

## Timing
- Bundle latency is 1 cycle: decode in cycle N appears on the `ex_*` outputs in cycle N+1.
- `stall`, the flush lines and `illegal` are combinational from the current inputs and state (0 cycles).
- Reset values:
  - All `ex_*` = 0, `ex_aluop` = 0, `ex_dst` = 0.
  - FSM = IDLE, counter = 0.
  - `stall` = 0 and all flush lines = 0 while the inputs are idle.
- Reset asserted mid-BUSY returns the FSM to IDLE immediately and asynchronously.
- Mult occupies EX for exactly MULT_CYCLES cycles:
  - 1 issue cycle plus MULT_CYCLES-1 stall cycles.
  - With MULT_CYCLES=1 there is no stall.
- Redirect and load-use in the same cycle: flush lines high, `stall`=1 and the next bundle is a bubble. The load-use stall still holds IF/ID for one cycle, so the squashed instruction re-decodes as a bubble because `id_flush` cleared it.

## Configuration
- Macro `DLX_CTRL_ILLEGAL_TRAP_EN`.
- Defined:
  - `illegal` is a sticky register. It sets on a valid illegal decode that is not flushed and clears only on reset.
  - While it is set, every bundle is a bubble and `stall`=1, which freezes the pipeline.
- Undefined:
  - `illegal` is a combinational one-cycle indication.
  - The illegal instruction issues as a NOP bubble and the pipeline continues.

## Structure
- Shared package `dlx_pkg` holds:
  - opcode localparams (ADDI…SW, JRf);
  - ALUOp constants (0x20 add, 0x22 sub, 0x11 nop-jump, etc.);
  - a packed `ctrl_bundle_t` struct.
- Sub-module `dlx_decode`: purely combinational opcode/funct to `ctrl_bundle_t` plus an illegal flag. It is the successor decode table.
- The top level holds the hazard logic, the FSM and the bundle register.

## Test plan
- **ADDI decode:** opcode 0x08, `id_valid`=1 → next cycle `ex_aluop`=0x20, `ex_alusrc`=1, `ex_regwrite`=1, `ex_dst`=`id_rt`.
- **Load-use:** LW r3 then ADD rs=r3 → one cycle `stall`=1, one bubble, then ADD issues. The same with r0 as the load destination → no stall.
- **Mult with MULT_CYCLES=4:** Mult issues → `stall` high for exactly 3 cycles, then the next instruction issues in cycle 5.
- **Branch:** `branch_taken`=1 → all three flush lines high in the same cycle and the next bundle has `ex_valid`=0. The same pulse during BUSY → the FSM count is unchanged.
- **Illegal opcode 0x3f:**
  - Macro undefined: `illegal` pulses for one cycle and the pipeline continues.
  - Macro defined: `illegal` stays 1 and `stall` stays 1 until `rst_n` is low.
- **Async reset mid-BUSY:** `rst_n` low → all outputs are 0 at once, the FSM is IDLE, and the first instruction after release decodes normally.
